// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: memory controller state encoding and bus defaults
// used by the datapath, the ISDU and the memory/I-O controller.
package slc3_pkg;

   localparam int          DEF_DATA_W  = 16;
   localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IO     = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

   // A wait counter always needs at least one bit, even with zero wait states.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/mem2io_ws_if.sv
// CPU-side request/response bus of the memory/I-O controller.
// The master is the datapath (MAR/MDR side); the slave is mem2io_ws.
interface mem2io_ws_if
   import slc3_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CPU_ADDR_W = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [CPU_ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/sync2.sv
// Parametrised-width two-flop synchroniser for slow asynchronous inputs
// such as board switches.
module sync2 #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/mem2io_ws.sv
// SLC-3 memory/I-O controller: valid/ready requests to a 1Mx16 SRAM with
// configurable wait states, plus one memory-mapped switch/hex-display register.
//
// state  | meaning
// IDLE   | ready for a request; SRAM deselected
// IO     | one-cycle switch read or hex write at IO_ADDR; SRAM untouched
// ACCESS | SRAM selected for WAIT_CYCLES+1 cycles; read data captured on the last
// DONE   | strobes released, write data still driven for hold; response pulse
module mem2io_ws
   import slc3_pkg::*;
#(
   parameter int                    DATA_W      = DEF_DATA_W,
   parameter int                    CPU_ADDR_W  = 16,
   parameter int                    SRAM_ADDR_W = 20,
   parameter int                    NUM_HEX     = 4,
   parameter int                    WAIT_CYCLES = 2,
   parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = CPU_ADDR_W'(DEF_IO_ADDR)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   mem2io_ws_if.slave             bus,
   input  logic [DATA_W-1:0]      switches,
   output logic [4*NUM_HEX-1:0]   hex_out,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      sram_rdata,
   output logic                   sram_drive_en
);

   localparam int CNT_W = cnt_width(WAIT_CYCLES);
   localparam int HEX_W = 4 * NUM_HEX;

   mem_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CPU_ADDR_W-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [HEX_W-1:0]      hex_q, hex_d;
   logic [DATA_W-1:0]     sw_sync;

   sync2 #(.WIDTH(DATA_W)) u_sw_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (switches),
      .q     (sw_sync)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         hex_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      hex_d          = hex_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      sram_ce_n      = 1'b1;
      sram_oe_n      = 1'b1;
      sram_we_n      = 1'b1;
      sram_ub_n      = 1'b1;
      sram_lb_n      = 1'b1;
      sram_drive_en  = 1'b0;

      unique case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               we_d    = bus.req_we;
               wdata_d = bus.req_wdata;
               if (bus.req_addr == IO_ADDR) begin
                  state_d = IO;
                  // Loaded on accept so the display shows the value during the IO cycle.
                  if (bus.req_we) hex_d = bus.req_wdata[HEX_W-1:0];
               end else begin
                  state_d = ACCESS;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
               end
            end
         end

         IO: begin
            bus.resp_valid = 1'b1;
            if (!we_q) rdata_d = sw_sync;
            state_d = IDLE;
         end

         ACCESS: begin
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            if (we_q) begin
               sram_we_n     = 1'b0;
               sram_drive_en = 1'b1;
            end else begin
               sram_oe_n = 1'b0;
            end
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!we_q) rdata_d = sram_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         DONE: begin
            bus.resp_valid = 1'b1;
            sram_drive_en  = we_q;
            state_d        = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // During an IO read the synchronised switches are presented directly so the
   // data is valid alongside the response pulse; the register holds it after.
   assign bus.resp_rdata = ((state_q == IO) && !we_q) ? sw_sync : rdata_q;
   assign hex_out        = hex_q;
   assign sram_addr      = SRAM_ADDR_W'(addr_q);
   assign sram_wdata     = wdata_q;

endmodule

// File: tb/tb_mem2io_ws.sv
// Directed bench for mem2io_ws: a 2-wait-state instance with the default I/O
// address and a 0-wait-state instance whose I/O address is moved to 16'hFF00.
module tb_mem2io_ws;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   mem2io_ws_if #(.DATA_W(16), .CPU_ADDR_W(16)) if_a ();
   mem2io_ws_if #(.DATA_W(16), .CPU_ADDR_W(16)) if_b ();

   logic [15:0] switches;
   logic [15:0] hex_a, hex_b, wdata_a, wdata_b, rdin_a, rdin_b;
   logic [19:0] addr_a, addr_b;
   logic ce_a, oe_a, we_a, ub_a, lb_a, drv_a;
   logic ce_b, oe_b, we_b, ub_b, lb_b, drv_b;

   mem2io_ws #(.WAIT_CYCLES(2)) dut_a (
      .Clk           (Clk),
      .Reset         (Reset),
      .bus           (if_a),
      .switches      (switches),
      .hex_out       (hex_a),
      .sram_addr     (addr_a),
      .sram_ce_n     (ce_a),
      .sram_oe_n     (oe_a),
      .sram_we_n     (we_a),
      .sram_ub_n     (ub_a),
      .sram_lb_n     (lb_a),
      .sram_wdata    (wdata_a),
      .sram_rdata    (rdin_a),
      .sram_drive_en (drv_a)
   );

   mem2io_ws #(.WAIT_CYCLES(0), .IO_ADDR(16'hFF00)) dut_b (
      .Clk           (Clk),
      .Reset         (Reset),
      .bus           (if_b),
      .switches      (switches),
      .hex_out       (hex_b),
      .sram_addr     (addr_b),
      .sram_ce_n     (ce_b),
      .sram_oe_n     (oe_b),
      .sram_we_n     (we_b),
      .sram_ub_n     (ub_b),
      .sram_lb_n     (lb_b),
      .sram_wdata    (wdata_b),
      .sram_rdata    (rdin_b),
      .sram_drive_en (drv_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset          = 1'b1;
      switches       = 16'h0000;
      rdin_a         = 16'h0000;
      rdin_b         = 16'h0000;
      if_a.req_valid = 1'b0;
      if_a.req_we    = 1'b0;
      if_a.req_addr  = 16'h0000;
      if_a.req_wdata = 16'h0000;
      if_b.req_valid = 1'b0;
      if_b.req_we    = 1'b0;
      if_b.req_addr  = 16'h0000;
      if_b.req_wdata = 16'h0000;

      // Reset values
      #12;
      chk("rst resp_valid", if_a.resp_valid, 1'b0);
      chk("rst req_ready", if_a.req_ready, 1'b1);
      chk("rst ce_n", ce_a, 1'b1);
      chk("rst oe_n", oe_a, 1'b1);
      chk("rst we_n", we_a, 1'b1);
      chk("rst ub_n", ub_a, 1'b1);
      chk("rst lb_n", lb_a, 1'b1);
      chk("rst drive_en", drv_a, 1'b0);
      chk("rst resp_rdata", if_a.resp_rdata, 16'h0000);
      chk("rst hex_out", hex_a, 16'h0000);
      chk("rst sram_addr", addr_a, 20'h00000);
      @(negedge Clk);
      Reset = 1'b0;
      tick();

      // SRAM write 16'h1234 -> 16'h0010, accepted at edge T
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b1;
      if_a.req_addr  = 16'h0010;
      if_a.req_wdata = 16'h1234;
      tick();
      if_a.req_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("wr we_n T+%0d", i), we_a, (i <= 3) ? 1'b0 : 1'b1);
         chk($sformatf("wr ce_n T+%0d", i), ce_a, (i <= 3) ? 1'b0 : 1'b1);
         chk($sformatf("wr oe_n T+%0d", i), oe_a, 1'b1);
         chk($sformatf("wr drive_en T+%0d", i), drv_a, (i <= 4) ? 1'b1 : 1'b0);
         chk($sformatf("wr resp_valid T+%0d", i), if_a.resp_valid, (i == 4) ? 1'b1 : 1'b0);
         chk($sformatf("wr req_ready T+%0d", i), if_a.req_ready, (i == 5) ? 1'b1 : 1'b0);
         chk($sformatf("wr sram_addr T+%0d", i), addr_a, 20'h00010);
         chk($sformatf("wr sram_wdata T+%0d", i), wdata_a, 16'h1234);
         tick();
      end

      // SRAM read 16'h0010 with the bus returning 16'h1234
      rdin_a         = 16'h1234;
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b0;
      if_a.req_addr  = 16'h0010;
      tick();
      if_a.req_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("rd oe_n T+%0d", i), oe_a, (i <= 3) ? 1'b0 : 1'b1);
         chk($sformatf("rd we_n T+%0d", i), we_a, 1'b1);
         chk($sformatf("rd drive_en T+%0d", i), drv_a, 1'b0);
         chk($sformatf("rd resp_valid T+%0d", i), if_a.resp_valid, (i == 4) ? 1'b1 : 1'b0);
         chk($sformatf("rd req_ready T+%0d", i), if_a.req_ready, (i == 5) ? 1'b1 : 1'b0);
         if (i == 3) chk("rd resp_rdata before capture", if_a.resp_rdata, 16'h0000);
         if (i == 4) chk("rd resp_rdata at resp", if_a.resp_rdata, 16'h1234);
         tick();
      end
      rdin_a = 16'hDEAD;
      tick();
      chk("rd resp_rdata held", if_a.resp_rdata, 16'h1234);

      // I/O write 16'hABCD -> 16'hFFFF
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b1;
      if_a.req_addr  = 16'hFFFF;
      if_a.req_wdata = 16'hABCD;
      tick();
      if_a.req_valid = 1'b0;
      chk("iow hex_out T+1", hex_a, 16'hABCD);
      chk("iow resp_valid T+1", if_a.resp_valid, 1'b1);
      chk("iow req_ready T+1", if_a.req_ready, 1'b0);
      chk("iow ce_n T+1", ce_a, 1'b1);
      chk("iow we_n T+1", we_a, 1'b1);
      chk("iow resp_rdata kept", if_a.resp_rdata, 16'h1234);
      tick();
      chk("iow resp_valid T+2", if_a.resp_valid, 1'b0);
      chk("iow req_ready T+2", if_a.req_ready, 1'b1);
      chk("iow ce_n T+2", ce_a, 1'b1);
      chk("iow hex_out T+2", hex_a, 16'hABCD);

      // I/O read with stable switches
      switches = 16'h5A5A;
      tick();
      tick();
      tick();
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b0;
      if_a.req_addr  = 16'hFFFF;
      tick();
      if_a.req_valid = 1'b0;
      chk("ior resp_valid T+1", if_a.resp_valid, 1'b1);
      chk("ior resp_rdata T+1", if_a.resp_rdata, 16'h5A5A);
      chk("ior ce_n T+1", ce_a, 1'b1);
      chk("ior oe_n T+1", oe_a, 1'b1);
      tick();
      chk("ior resp_valid T+2", if_a.resp_valid, 1'b0);
      chk("ior resp_rdata T+2", if_a.resp_rdata, 16'h5A5A);

      // Switch change one cycle before the IO cycle returns the old value
      switches       = 16'h1111;
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b0;
      if_a.req_addr  = 16'hFFFF;
      tick();
      if_a.req_valid = 1'b0;
      chk("ior late resp_valid", if_a.resp_valid, 1'b1);
      chk("ior late resp_rdata", if_a.resp_rdata, 16'h5A5A);
      tick();
      chk("ior late held", if_a.resp_rdata, 16'h5A5A);
      tick();
      if_a.req_valid = 1'b1;
      tick();
      if_a.req_valid = 1'b0;
      chk("ior new resp_rdata", if_a.resp_rdata, 16'h1111);
      tick();

      // Reset asserted in cycle T+2 of an SRAM write
      if_a.req_valid = 1'b1;
      if_a.req_we    = 1'b1;
      if_a.req_addr  = 16'h0020;
      if_a.req_wdata = 16'h0F0F;
      tick();
      if_a.req_valid = 1'b0;
      chk("abort we_n T+1", we_a, 1'b0);
      tick();
      chk("abort we_n T+2", we_a, 1'b0);
      Reset = 1'b1;
      #1;
      chk("abort ce_n", ce_a, 1'b1);
      chk("abort we_n", we_a, 1'b1);
      chk("abort drive_en", drv_a, 1'b0);
      chk("abort req_ready", if_a.req_ready, 1'b1);
      chk("abort resp_valid", if_a.resp_valid, 1'b0);
      chk("abort hex_out", hex_a, 16'h0000);
      chk("abort resp_rdata", if_a.resp_rdata, 16'h0000);
      chk("abort sram_addr", addr_a, 20'h00000);
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("abort no resp %0d", i), if_a.resp_valid, 1'b0);
         chk($sformatf("abort idle ce_n %0d", i), ce_a, 1'b1);
      end

      // Zero wait states, moved IO_ADDR: back-to-back read of 16'hFFFF then write
      rdin_b         = 16'h7777;
      if_b.req_valid = 1'b1;
      if_b.req_we    = 1'b0;
      if_b.req_addr  = 16'hFFFF;
      tick();
      chk("b2b rd oe_n T+1", oe_b, 1'b0);
      chk("b2b rd ce_n T+1", ce_b, 1'b0);
      chk("b2b rd req_ready T+1", if_b.req_ready, 1'b0);
      chk("b2b rd resp_valid T+1", if_b.resp_valid, 1'b0);
      chk("b2b rd sram_addr T+1", addr_b, 20'h0FFFF);
      tick();
      chk("b2b rd resp_valid T+2", if_b.resp_valid, 1'b1);
      chk("b2b rd resp_rdata T+2", if_b.resp_rdata, 16'h7777);
      chk("b2b rd oe_n T+2", oe_b, 1'b1);
      chk("b2b rd req_ready T+2", if_b.req_ready, 1'b0);
      if_b.req_we    = 1'b1;
      if_b.req_addr  = 16'h0042;
      if_b.req_wdata = 16'hBEEF;
      tick();
      chk("b2b req_ready T+3", if_b.req_ready, 1'b1);
      chk("b2b resp_valid T+3", if_b.resp_valid, 1'b0);
      chk("b2b ce_n T+3", ce_b, 1'b1);
      tick();
      if_b.req_valid = 1'b0;
      chk("b2b wr we_n T+4", we_b, 1'b0);
      chk("b2b wr drive_en T+4", drv_b, 1'b1);
      chk("b2b wr sram_addr T+4", addr_b, 20'h00042);
      chk("b2b wr sram_wdata T+4", wdata_b, 16'hBEEF);
      chk("b2b wr resp_valid T+4", if_b.resp_valid, 1'b0);
      tick();
      chk("b2b wr resp_valid T+5", if_b.resp_valid, 1'b1);
      chk("b2b wr we_n T+5", we_b, 1'b1);
      chk("b2b wr drive_en T+5", drv_b, 1'b1);
      tick();
      chk("b2b wr resp_valid T+6", if_b.resp_valid, 1'b0);
      chk("b2b wr drive_en T+6", drv_b, 1'b0);
      chk("b2b req_ready T+6", if_b.req_ready, 1'b1);
      chk("b2b resp_rdata held", if_b.resp_rdata, 16'h7777);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
